// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing defaults and helpers
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    function automatic int timing_total(input int visible, input int front,
                                        input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/sync_counter.sv
// rtl/sync_counter.sv - one raster axis: position counter with registered sync/active decode
module sync_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE  = H_VISIBLE_DEF,
    parameter int FRONT    = H_FRONT_DEF,
    parameter int SYNC     = H_SYNC_DEF,
    parameter int BACK     = H_BACK_DEF,
    parameter int SYNC_POL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] pos,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam int TOTAL = timing_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);
    localparam logic ASSERTED = (SYNC_POL != 0);

    logic [CNT_W-1:0] pos_nxt;

    assign wrap = (pos == LAST);

    always_comb begin
        pos_nxt = pos;
        if (advance) begin
            pos_nxt = wrap ? '0 : pos + CNT_W'(1);
        end
    end

    // Flags decode the next position so they line up with pos after the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos    <= LAST;
            sync   <= ~ASSERTED;
            active <= 1'b0;
        end else begin
            pos    <= pos_nxt;
            active <= (pos_nxt < VIS_END);
            sync   <= ((pos_nxt >= SYNC_START) && (pos_nxt < SYNC_END)) ? ASSERTED : ~ASSERTED;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, h/v counters, line/frame pulses
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int SYNC_POL  = 0,
    parameter int CLK_DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] colPos,
    output logic [CNT_W-1:0] rowPos,
    output logic             pix_en,
    output logic             visible,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    if (timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK) > MAX_TOTAL ||
        timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK) > MAX_TOTAL ||
        CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             h_active;
    logic             v_active;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_advance;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Gated by rst_n so CLK_DIV==1 advances on the very first edge after release.
    assign pix_en    = rst_n & (div_cnt == DIV_LAST);
    assign v_advance = pix_en & h_wrap;

    sync_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(SYNC_POL)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .advance(pix_en),
        .pos(colPos), .sync(hsync), .active(h_active), .wrap(h_wrap)
    );

    sync_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(SYNC_POL)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .advance(v_advance),
        .pos(rowPos), .sync(vsync), .active(v_active), .wrap(v_wrap)
    );

    assign visible = h_active & v_active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'hFF;
        end else begin
            line_start  <= v_advance;
            frame_start <= v_advance & v_wrap;
            if (v_advance && v_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

    typedef struct {
        int col; int row; int pix_en; int visible;
        int hsync; int vsync; int ls; int fs; int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] a_col, a_row, b_col, b_row, c_col, c_row;
    logic       a_pe, a_vis, a_hs, a_vs, a_ls, a_fs;
    logic       b_pe, b_vis, b_hs, b_vs, b_ls, b_fs;
    logic       c_pe, c_vis, c_hs, c_vs, c_ls, c_fs;
    logic [7:0] a_fc, b_fc, c_fc;

    // Small rasters keep many frames within a short run; c uses the real 640x480 timing.
    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                     .SYNC_POL(0), .CLK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .colPos(a_col), .rowPos(a_row), .pix_en(a_pe),
        .visible(a_vis), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
        .frame_start(a_fs), .frame_count(a_fc));

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                     .SYNC_POL(1), .CLK_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .colPos(b_col), .rowPos(b_row), .pix_en(b_pe),
        .visible(b_vis), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
        .frame_start(b_fs), .frame_count(b_fc));

    vga_timing_gen dut_c (
        .clk(clk), .rst_n(rst_n), .colPos(c_col), .rowPos(c_row), .pix_en(c_pe),
        .visible(c_vis), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls),
        .frame_start(c_fs), .frame_count(c_fc));

    exp_t q_a[$], q_b[$], q_c[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    int   fs_seen_a = 0;
    int   fs_want_a = 0;

    // k = clean edges since the last reset edge; everything follows from pixel count a = k/d.
    function automatic exp_t model(input int k_edges, input bit rst_now,
                                   input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb,
                                   input int pol, input int d);
        exp_t e;
        int ht, vt, n, a, p, frames;
        bit adv_edge;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        n  = ht * vt;
        a  = k_edges / d;
        p  = (a + n - 1) % n;
        e.col = p % ht;
        e.row = p / ht;
        e.visible = (e.col < hv && e.row < vv) ? 1 : 0;
        e.hsync = (e.col >= hv + hf && e.col < hv + hf + hs) ? pol : 1 - pol;
        e.vsync = (e.row >= vv + vf && e.row < vv + vf + vs) ? pol : 1 - pol;
        adv_edge = (k_edges >= 1) && (k_edges % d == 0);
        e.ls = (adv_edge && e.col == 0) ? 1 : 0;
        e.fs = (e.ls == 1 && e.row == 0) ? 1 : 0;
        frames = (a == 0) ? 0 : (a - 1) / n + 1;
        e.fc = (frames - 1) & 255;
        e.pix_en = (rst_now && (k_edges % d == d - 1)) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input int col, input int row,
                       input int pe, input int vis, input int hs, input int vs,
                       input int ls, input int fs, input int fc);
        chk({t, ".colPos"}, col, e.col);
        chk({t, ".rowPos"}, row, e.row);
        chk({t, ".pix_en"}, pe, e.pix_en);
        chk({t, ".visible"}, vis, e.visible);
        chk({t, ".hsync"}, hs, e.hsync);
        chk({t, ".vsync"}, vs, e.vsync);
        chk({t, ".line_start"}, ls, e.ls);
        chk({t, ".frame_start"}, fs, e.fs);
        chk({t, ".frame_count"}, fc, e.fc);
    endtask

    task automatic step(input bit nxt);
        exp_t ea;
        @(posedge clk);
        k = rst_n ? k + 1 : 0;
        #1 rst_n = nxt;
        ea = model(k, nxt, 8, 2, 3, 2, 4, 1, 2, 2, 0, 1);
        if (ea.fs == 1) fs_want_a++;
        q_a.push_back(ea);
        q_b.push_back(model(k, nxt, 8, 2, 3, 2, 4, 1, 2, 2, 1, 3));
        q_c.push_back(model(k, nxt, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1));
    endtask

    // Monitor: DUT outputs are valid every cycle; compare away from the active edge.
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            exp_t e;
            e = q_a.pop_front();
            if (a_fs === 1'b1) fs_seen_a++;
            cmp("a", e, a_col, a_row, a_pe, a_vis, a_hs, a_vs, a_ls, a_fs, a_fc);
        end
        if (q_b.size() > 0) begin
            exp_t e;
            e = q_b.pop_front();
            cmp("b", e, b_col, b_row, b_pe, b_vis, b_hs, b_vs, b_ls, b_fs, b_fc);
        end
        if (q_c.size() > 0) begin
            exp_t e;
            e = q_c.pop_front();
            cmp("c", e, c_col, c_row, c_pe, c_vis, c_hs, c_vs, c_ls, c_fs, c_fc);
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (256 * 135 + 40) step(1'b1);
        repeat (6000) step($urandom_range(0, 399) != 0);
        repeat (4) step($urandom_range(0, 1) != 0);
        repeat (20) step(1'b1);
        repeat (3) @(negedge clk);
        chk("a.frame_start_total", fs_seen_a, fs_want_a);
        if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_a.size() + q_b.size() + q_c.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
